// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Glyph codes are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs 0-F; "b" and "d" are lowercase so they differ from 8 and 0.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH[hex];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with inter-digit blanking
// and frame-boundary word swap. Define SSEG_LZB_EN for leading-zero blanking.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] D_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  scan_state_t     state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [W-1:0]    active, active_n;
  logic [W-1:0]    shadow, shadow_n;
  logic            pending_n;
  logic            wrap;
  logic [3:0]      nibble;
  logic [6:0]      glyph_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0]      seg_n;
  logic            frame_done_n;
  logic            lz_blank;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    wrap      = 1'b0;
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;

    case (state)
      BLANK: begin
        if (cnt == B_LAST) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (cnt == D_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx == I_LAST) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = BLANK;
    endcase

    // A load on the wrap cycle bypasses the shadow so it lands this frame.
    if (wrap) begin
      if (load) begin
        active_n  = value_in;
        shadow_n  = value_in;
        pending_n = 1'b0;
      end else if (pending) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end
    end else if (load) begin
      shadow_n  = value_in;
      pending_n = 1'b1;
    end
  end

  assign nibble = active_n[4*idx_n +: 4];

  hex_to_sseg u_dec (
    .hex (nibble),
    .seg (glyph_n)
  );

`ifdef SSEG_LZB_EN
  // Blank when this nibble and every more-significant one are zero.
  always_comb begin
    lz_blank = (idx_n != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_n) && active_n[4*j +: 4] != 4'h0) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs are built from next-state values so they align with the state
  // register and leave the flops glitch-free.
  always_comb begin
    an_n  = '1;
    seg_n = SEG_OFF;
    if (state_n == DRIVE && !lz_blank) begin
      an_n[idx_n] = 1'b0;
      seg_n       = glyph_n;
    end
    frame_done_n = (state_n == DRIVE) && (cnt_n == D_LAST) && (idx_n == I_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      active     <= active_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver (4 digits, 8 drive / 2 blank ticks).
module tb_sseg_scan_driver;

  localparam int ND   = 4;
  localparam int DT   = 8;
  localparam int BT   = 2;
  localparam int SLOT = BT + DT;
  localparam int FR   = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .NUM_DIGITS  (ND),
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .pending    (pending)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       pend;
  } exp_t;

  localparam logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          p     = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_sh  = '0;
  bit          m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s pos=%0d got=%h exp=%h", tag, p, got, exp);
    end
  endtask

  // Expected outputs at frame position p, derived from slot arithmetic.
  function automatic exp_t expect_at();
    exp_t e;
    int q, slot, r;
    bit blanked;
    q    = p % FR;
    slot = q / SLOT;
    r    = q % SLOT;
    e.an   = 4'hF;
    e.seg  = 7'h7F;
    e.fd   = (q == FR - 1);
    e.pend = m_pend;
    blanked = 1'b0;
`ifdef SSEG_LZB_EN
    blanked = (slot != 0) && ((m_act >> (4 * slot)) == 16'h0);
`endif
    if (r >= BT && !blanked) begin
      e.an[slot] = 1'b0;
      e.seg      = GL[m_act[4*slot +: 4]];
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    if (rst) begin
      p = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
    end else begin
      if (p % FR == FR - 1) begin
        if (load) begin
          m_act = value_in; m_sh = value_in; m_pend = 1'b0;
        end else if (m_pend) begin
          m_act = m_sh; m_pend = 1'b0;
        end
      end else if (load) begin
        m_sh = value_in; m_pend = 1'b1;
      end
      p++;
    end
    sb.push_back(expect_at());
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("an", 32'(an), 32'(e.an));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
    chk("pending", 32'(pending), 32'(e.pend));
  endtask

  task automatic run(input int n);
    load = 1'b0;
    repeat (n) tick();
  endtask

  task automatic ld(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic to_pos(input int target);
    int guard;
    guard = 0;
    load  = 1'b0;
    while (p % FR != target && guard <= FR) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    run(FR);

    // Mid-frame load, shown from next frame.
    to_pos(15);
    ld(16'h12AF);
    to_pos(0);
    run(FR);

    // Last of two loads wins.
    to_pos(5);
    ld(16'h1111);
    to_pos(20);
    ld(16'h2222);
    to_pos(0);
    run(FR);

    // Load exactly on the wrap cycle.
    to_pos(FR - 1);
    ld(16'h0005);
    run(FR);

    // Reset during digit 2 drive with a word pending.
    to_pos(3);
    ld(16'hBEEF);
    to_pos(24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(FR);

    // Leading-zero pattern, then a few random loads.
    to_pos(7);
    ld(16'h0030);
    to_pos(0);
    run(FR);
    repeat (6) begin
      to_pos($urandom_range(FR - 1));
      ld(16'($urandom));
      run($urandom_range(3));
    end
    to_pos(0);
    run(FR);
    ld(16'h0000);
    to_pos(0);
    run(FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
